// File: rtl/hb_pkg.sv
// Shared definitions for the heartbeat receiver.
//   hb_state_t : monitor state encoding (IDLE/ARMED/ALIVE/TIMEOUT)
//   HB_DATA_W  : beat payload width
//   HB_MISS_W  : consecutive-miss counter width
package hb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ARMED   = 2'b01,
        ST_ALIVE   = 2'b10,
        ST_TIMEOUT = 2'b11
    } hb_state_t;

    localparam int unsigned HB_DATA_W = 32;
    localparam int unsigned HB_MISS_W = 8;

endpackage

// File: rtl/hb_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk      : clock, rising edge
//   i_rst    : synchronous active-high reset (count -> 0)
//   i_clr    : synchronous clear (count -> 0), wins over i_inc
//   i_inc    : increment request; ignored once count is all-ones
//   o_count  : current count
module hb_sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/recv_heartbeat.sv
// Heartbeat link receiver: watchdog window, beat/miss counters, timeout
// detection and interrupt.
// Optional feature macro: HB_SEQ_CHECK_EN (payload sequence checking;
// when undefined seq_err is tied low and no compare logic exists).
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   start        : arms the monitor from IDLE
//   stop         : returns to IDLE from any state
//   clear        : zeroes counters/window, clears sticky flags,
//                  TIMEOUT -> ARMED
//   hb_in        : one-cycle beat strobe
//   hb_data      : beat payload, valid with hb_in
//   alive        : high in ALIVE
//   timeout      : high in TIMEOUT
//   timeout_irq  : one-cycle pulse on entry to TIMEOUT
//   miss_count   : consecutive missed windows (saturating)
//   beat_count   : beats since arm/clear (saturating)
//   last_data    : payload of the most recent accepted beat
//   seq_err      : sticky payload sequence error
module recv_heartbeat
    import hb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned MISS_LIMIT     = 3,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 clear,
    input  logic                 hb_in,
    input  logic [HB_DATA_W-1:0] hb_data,
    output logic                 alive,
    output logic                 timeout,
    output logic                 timeout_irq,
    output logic [HB_MISS_W-1:0] miss_count,
    output logic [CNT_W-1:0]     beat_count,
    output logic [HB_DATA_W-1:0] last_data,
    output logic                 seq_err
);

    localparam int unsigned          WCNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WCNT_W-1:0]    WCNT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [HB_MISS_W-1:0] MISS_LIM  = HB_MISS_W'(MISS_LIMIT);

    hb_state_t            r_state;
    logic [WCNT_W-1:0]    r_wcnt;
    logic                 r_alive;
    logic                 r_timeout;
    logic                 r_timeout_irq;
    logic [HB_DATA_W-1:0] r_last_data;

    logic                 w_active;
    logic                 w_clear;
    logic                 w_arm;
    logic                 w_beat;
    logic                 w_expire;
    logic                 w_cnt_clr;
    logic [HB_MISS_W-1:0] w_miss;
    logic [HB_MISS_W-1:0] w_miss_next;
    logic [CNT_W-1:0]     w_beats;

    // Priority rst > stop > clear > beat > expiry is resolved here so the
    // counters and the FSM see one consistent decision per edge.
    assign w_active    = (r_state != ST_IDLE);
    assign w_clear     = clear && !stop;
    assign w_arm       = (r_state == ST_IDLE) && start && !stop;
    assign w_beat      = w_active && hb_in && !stop && !clear;
    assign w_expire    = w_active && !hb_in && !stop && !clear && (r_wcnt == WCNT_LAST);
    assign w_cnt_clr   = w_clear || w_arm;
    assign w_miss_next = (w_miss == '1) ? w_miss : w_miss + 1'b1;

    hb_sat_counter #(.WIDTH(CNT_W)) u_beat_cnt (
        .clk     (clk),
        .i_rst   (rst),
        .i_clr   (w_cnt_clr),
        .i_inc   (w_beat),
        .o_count (w_beats)
    );

    hb_sat_counter #(.WIDTH(HB_MISS_W)) u_miss_cnt (
        .clk     (clk),
        .i_rst   (rst),
        .i_clr   (w_cnt_clr || w_beat),
        .i_inc   (w_expire),
        .o_count (w_miss)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_wcnt        <= '0;
            r_alive       <= 1'b0;
            r_timeout     <= 1'b0;
            r_timeout_irq <= 1'b0;
            r_last_data   <= '0;
        end else begin
            r_timeout_irq <= 1'b0;
            if (stop) begin
                r_state   <= ST_IDLE;
                r_wcnt    <= '0;
                r_alive   <= 1'b0;
                r_timeout <= 1'b0;
            end else if (r_state == ST_IDLE) begin
                r_wcnt <= '0;
                if (start) begin
                    r_state <= ST_ARMED;
                end
            end else if (clear) begin
                r_wcnt <= '0;
                if (r_state == ST_TIMEOUT) begin
                    r_state   <= ST_ARMED;
                    r_timeout <= 1'b0;
                end
            end else if (hb_in) begin
                r_wcnt      <= '0;
                r_state     <= ST_ALIVE;
                r_alive     <= 1'b1;
                r_timeout   <= 1'b0;
                r_last_data <= hb_data;
            end else if (r_wcnt == WCNT_LAST) begin
                r_wcnt <= '0;
                if (w_miss_next >= MISS_LIM) begin
                    r_state   <= ST_TIMEOUT;
                    r_alive   <= 1'b0;
                    r_timeout <= 1'b1;
                    if (r_state != ST_TIMEOUT) begin
                        r_timeout_irq <= 1'b1;
                    end
                end
            end else begin
                r_wcnt <= r_wcnt + 1'b1;
            end
        end
    end

`ifdef HB_SEQ_CHECK_EN
    logic r_seq_err;
    logic r_seq_seen;   // a beat has been accepted since the last arm/clear

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seq_err  <= 1'b0;
            r_seq_seen <= 1'b0;
        end else if (w_cnt_clr) begin
            r_seq_seen <= 1'b0;
            if (w_clear) begin
                r_seq_err <= 1'b0;
            end
        end else if (w_beat) begin
            r_seq_seen <= 1'b1;
            if (r_seq_seen && (hb_data != r_last_data + 32'd1)) begin
                r_seq_err <= 1'b1;
            end
        end
    end

    assign seq_err = r_seq_err;
`else
    assign seq_err = 1'b0;
`endif

    assign alive       = r_alive;
    assign timeout     = r_timeout;
    assign timeout_irq = r_timeout_irq;
    assign miss_count  = w_miss;
    assign beat_count  = w_beats;
    assign last_data   = r_last_data;

endmodule

// File: doc/recv_heartbeat.md
Name: recv_heartbeat

Overview:
Receiving end of the heartbeat link. Watches the one-cycle completion pulse and 32-bit result word from a heartbeat sender. Runs a watchdog window, counts beats and consecutive missed windows, and declares a timeout after MISS_LIMIT consecutive misses. Sits in the FPGA supervision path beside the sender and drives status and interrupt lines to the host-visible register block.

Parameters:
TIMEOUT_CYCLES, 1000, watchdog window length in clk cycles; must be >= 2.
MISS_LIMIT, 3, consecutive missed windows before timeout; must be 1..255.
CNT_W, 16, width of beat_count; counter saturates at all-ones.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  synchronous active-high reset.
start  input  1  level; arms the monitor when sampled high in IDLE.
stop  input  1  level; returns to IDLE from any state.
clear  input  1  one-cycle pulse; clears the sticky timeout and seq_err flags and zeroes all counters.
hb_in  input  1  one-cycle beat strobe (the sender's done).
hb_data  input  32  beat payload, valid when hb_in = 1.
alive  output  1  high in ALIVE.
timeout  output  1  high in TIMEOUT.
timeout_irq  output  1  one-cycle pulse on entry to TIMEOUT.
miss_count  output  8  consecutive missed windows, saturating at 255.
beat_count  output  CNT_W  beats received since arm or clear, saturating.
last_data  output  32  hb_data captured on the most recent beat.
seq_err  output  1  sticky sequence error; only active with the optional feature.

Behaviour:
- Reset:
  - Interface: one clock, clk. Reset rst is synchronous and active-high.
  - Reset drives: state = IDLE, every output 0, internal window counter wcnt = 0.
- State IDLE:
  - wcnt is held at 0 and beats are ignored.
  - start = 1 moves to ARMED on the next edge and zeroes wcnt, miss_count and beat_count.
  - last_data is retained.
- States ARMED, ALIVE and TIMEOUT (the active states):
  - wcnt increments by 1 every cycle.
  - A beat (hb_in = 1) does all of the following on the same edge:
    - sets wcnt = 0 and miss_count = 0;
    - increments beat_count, saturating;
    - sets last_data = hb_data;
    - moves to ALIVE.
  - Expiry: wcnt == TIMEOUT_CYCLES-1 with no beat. On expiry, wcnt goes to 0 and miss_count increments, saturating.
  - If the new miss_count is >= MISS_LIMIT, the state becomes TIMEOUT.
  - On entry to TIMEOUT, timeout_irq pulses for exactly one cycle.
  - In TIMEOUT, further expiries keep incrementing miss_count but never re-pulse the irq.
  - A beat in TIMEOUT recovers the block to ALIVE and timeout deasserts the next cycle.
- Priority per edge, highest first: rst, stop, clear, beat, expiry.
  - A beat coinciding with expiry counts as a beat, and no miss is recorded.
  - stop coinciding with a beat goes to IDLE and the beat is dropped.
  - clear in an active state zeroes the counters and wcnt, leaves the state unchanged except TIMEOUT → ARMED, and drops a coincident beat.
- Latency: all outputs are registered. A beat on edge N shows as alive = 1 and the updated counters after edge N.
- start is ignored outside IDLE.
- Reset asserted mid-window aborts silently. No irq is issued.

Optional Feature:
HB_SEQ_CHECK_EN.
- Defined:
  - On each beat after the first since arm or clear, hb_data must equal previous last_data + 1, modulo 2^32.
  - On a mismatch, seq_err sets sticky until clear or rst. The beat is still accepted normally.
  - The first beat after arm or clear is never checked.
- Undefined: seq_err is tied to 0 and no comparison logic is built.

Decomposition:
- Shared package hb_pkg holds:
  - the state encoding: IDLE = 2'b00, ARMED = 2'b01, ALIVE = 2'b10, TIMEOUT = 2'b11;
  - the payload width 32;
  - the miss_count width 8.
- One sub-module: hb_sat_counter, a parameterised width up-counter with clear and saturation, used for both beat_count and miss_count.
- The window counter stays inline.

Test Plan:
1. TIMEOUT_CYCLES=10, MISS_LIMIT=3; start, then a beat every 8 cycles for 20 beats → alive=1 throughout, beat_count=20, miss_count=0, no timeout_irq.
2. Same parameters; start, then no beats → miss_count reaches 3 at cycle 30, timeout=1, timeout_irq high for exactly 1 cycle; a later beat with hb_data=32'hA5 → alive=1, miss_count=0, last_data=32'hA5.
3. Beat placed on exactly the expiry cycle (wcnt=9) → miss_count stays 0 and wcnt restarts at 0.
4. Drive into TIMEOUT, then pulse clear → state ARMED, timeout=0, all counters 0; stop plus hb_in in the same cycle → IDLE and beat_count unchanged.
5. HB_SEQ_CHECK_EN defined; beats with data 5, 6, 8 → seq_err rises after the third beat and stays high; clear → seq_err=0. Build without the macro, same stimulus → seq_err stays 0.
6. CNT_W=4; 20 beats → beat_count saturates at 15. rst asserted mid-window → all outputs 0 on the next cycle, no irq.
